// File: rtl/regfile_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared defaults and index helpers for the multi-port register
//            file. The top register index is the PC. The index just below
//            it is the link register.
// Revision : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int c_def_data_w      = 32;
    localparam int c_def_nregs       = 16;
    localparam int c_def_nrd         = 2;
    localparam int c_def_pc_inc      = 4;
    localparam int c_def_pc_read_ofs = 8;
    localparam int c_def_pc_reset    = 0;

    // Smallest r such that 2**r >= n
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

    // Link register: second-highest architectural index
    function automatic int lr_idx(input int nregs);
        return nregs - 2;
    endfunction

    // Program counter: highest architectural index
    function automatic int pc_idx(input int nregs);
        return nregs - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_mp_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Brief    : Program counter register with the next-PC priority mux.
//            The priority order is reset, then stall-hold, then branch,
//            then explicit PC write, then sequential increment.
//            It also outputs the link value (PC + increment).
// Revision : 1.0  initial release
// ============================================================================
module pc_unit
    import regfile_pkg::*;
#(
    parameter int                 DATA_W   = c_def_data_w,
    parameter int                 PC_INC   = c_def_pc_inc,
    parameter logic [DATA_W-1:0]  PC_RESET = DATA_W'(c_def_pc_reset)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              ib,
    input  logic [DATA_W-1:0] bv,
    input  logic              pcwe,
    input  logic [DATA_W-1:0] pcwd,
    output logic [DATA_W-1:0] iaddr,
    output logic [DATA_W-1:0] link
);

    logic [DATA_W-1:0] r_pc;

    // Sequential increment wraps naturally at 2**DATA_W
    assign link  = r_pc + DATA_W'(PC_INC);
    assign iaddr = r_pc;

    // Next-PC selection in strict priority order
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= PC_RESET;
        end else if (stall) begin
            r_pc <= r_pc;
        end else if (ib) begin
            r_pc <= bv;
        end else if (pcwe) begin
            r_pc <= pcwd;
        end else begin
            r_pc <= link;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Parametrised register file with NRD registered read ports, two
//            write ports, a link write and an integrated PC (index NREGS-1).
//            Optional macro REGFILE_BYPASS_EN forwards same-edge writes to
//            reads. The forwarding priority is link, then port 0, then port 1.
// Revision : 1.0  initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int                 DATA_W      = c_def_data_w,
    parameter int                 NREGS       = c_def_nregs,
    parameter int                 NRD         = c_def_nrd,
    parameter int                 PC_INC      = c_def_pc_inc,
    parameter int                 PC_READ_OFS = c_def_pc_read_ofs,
    parameter logic [DATA_W-1:0]  PC_RESET    = DATA_W'(c_def_pc_reset),
    localparam int                c_aw        = clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic [NRD*c_aw-1:0]     ra,
    output logic [NRD*DATA_W-1:0]   rd,
    input  logic                    we0,
    input  logic [c_aw-1:0]         wa0,
    input  logic [DATA_W-1:0]       wd0,
    input  logic                    we1,
    input  logic [c_aw-1:0]         wa1,
    input  logic [DATA_W-1:0]       wd1,
    input  logic                    ib,
    input  logic [DATA_W-1:0]       bv,
    input  logic                    bl,
    output logic [DATA_W-1:0]       iaddr
);

    localparam logic [c_aw-1:0] c_pc_a = c_aw'(pc_idx(NREGS));
    localparam logic [c_aw-1:0] c_lr_a = c_aw'(lr_idx(NREGS));

    logic [DATA_W-1:0] r_regs [NREGS-1];

    logic              w_link_we;
    logic              w_p0_we;
    logic              w_p1_we;
    logic              w_pc_we0;
    logic              w_pc_we1;
    logic              w_pcwe;
    logic [DATA_W-1:0] w_pcwd;
    logic [DATA_W-1:0] w_link;

    // Link is suppressed while stalled, together with the branch itself
    assign w_link_we = ib & bl & ~stall;
    assign w_p0_we   = we0 & (wa0 != c_pc_a);
    assign w_p1_we   = we1 & (wa1 != c_pc_a);
    assign w_pc_we0  = we0 & (wa0 == c_pc_a);
    assign w_pc_we1  = we1 & (wa1 == c_pc_a);
    assign w_pcwe    = w_pc_we0 | w_pc_we1;
    assign w_pcwd    = w_pc_we0 ? wd0 : wd1;

    pc_unit #(
        .DATA_W   (DATA_W),
        .PC_INC   (PC_INC),
        .PC_RESET (PC_RESET)
    ) u_pc (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .ib    (ib),
        .bv    (bv),
        .pcwe  (w_pcwe),
        .pcwd  (w_pcwd),
        .iaddr (iaddr),
        .link  (w_link)
    );

    for (genvar i = 0; i < NREGS - 1; i++) begin : g_reg
        localparam logic [c_aw-1:0] c_idx = c_aw'(i);
        localparam bit              c_is_lr = (c_idx == c_lr_a);

        // One architectural register with link > port 0 > port 1 priority
        always_ff @(posedge clk) begin
            if (rst) begin
                r_regs[i] <= '0;
            end else if (c_is_lr && w_link_we) begin
                r_regs[i] <= w_link;
            end else if (w_p0_we && (wa0 == c_idx)) begin
                r_regs[i] <= wd0;
            end else if (w_p1_we && (wa1 == c_idx)) begin
                r_regs[i] <= wd1;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [c_aw-1:0]   w_ra;
        logic [DATA_W-1:0] w_rdata;
        logic [DATA_W-1:0] r_rd;

        assign w_ra = ra[k*c_aw +: c_aw];
        assign rd[k*DATA_W +: DATA_W] = r_rd;

        // Array read, optionally forwarding a write committing on this edge
        always_comb begin
            w_rdata = r_regs[w_ra];
`ifdef REGFILE_BYPASS_EN
            if (w_link_we && (w_ra == c_lr_a)) begin
                w_rdata = w_link;
            end else if (w_p0_we && (wa0 == w_ra)) begin
                w_rdata = wd0;
            end else if (w_p1_we && (wa1 == w_ra)) begin
                w_rdata = wd1;
            end
`endif
        end

        // Registered read port; PC index returns the pre-edge PC plus offset
        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd <= '0;
            end else if (!stall) begin
                if (w_ra == c_pc_a) begin
                    r_rd <= iaddr + DATA_W'(PC_READ_OFS);
                end else begin
                    r_rd <= w_rdata;
                end
            end
        end
    end

endmodule
`default_nettype wire
